// File: rtl/corr_window_ctrl.sv
// corr_window_ctrl: window sequencer that times count windows and captures engine counts at each boundary
module corr_window_ctrl #(
  parameter int DATA_W = 16,
  parameter int TIME_W = 8,
  localparam int EW = $clog2(TIME_W + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cg,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [EW-1:0]     i_windowLengthExp,
  input  logic [15:0]       i_nWindows,
  output logic [TIME_W-1:0] o_t,
  output logic              o_zeroCounts,
  output logic [EW-1:0]     o_windowLengthExp,
  input  logic [DATA_W-1:0] i_countX,
  input  logic [DATA_W-1:0] i_countY,
  input  logic [DATA_W-1:0] i_countIsect,
  input  logic [DATA_W-1:0] i_countSymdiff,
  output logic              o_rsltValid,
  input  logic              i_rsltReady,
  output logic [DATA_W-1:0] o_rsltX,
  output logic [DATA_W-1:0] o_rsltY,
  output logic [DATA_W-1:0] o_rsltIsect,
  output logic [DATA_W-1:0] o_rsltSymdiff,
  output logic [15:0]       o_rsltIdx,
  output logic              o_overflow,
  output logic              o_busy
);
  localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;
  logic [0:0] state;
  logic [15:0] nwin, win_cnt;
  logic first_done, cap, done;
  logic [TIME_W:0] span;
  logic [TIME_W-1:0] t_next;
  // first_done rather than win_cnt>=1 so captures survive the 16-bit counter wrap
  always_comb begin
    span = ((TIME_W+1)'(1) << o_windowLengthExp) - (TIME_W+1)'(1);
    t_next = (o_t + TIME_W'(1)) & span[TIME_W-1:0];
    cap = state == RUN && o_zeroCounts && first_done;
    done = cap && nwin != 16'd0 && win_cnt == nwin;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      o_t <= '0;
      o_zeroCounts <= 1'b1;
      o_windowLengthExp <= '0;
      nwin <= '0;
      win_cnt <= '0;
      first_done <= 1'b0;
      o_rsltValid <= 1'b0;
      o_rsltX <= '0;
      o_rsltY <= '0;
      o_rsltIsect <= '0;
      o_rsltSymdiff <= '0;
      o_rsltIdx <= '0;
      o_overflow <= 1'b0;
      o_busy <= 1'b0;
    end else if (i_cg) begin
      if (cap) begin
        if (!o_rsltValid || i_rsltReady) begin
          o_rsltValid <= 1'b1;
          o_rsltX <= i_countX;
          o_rsltY <= i_countY;
          o_rsltIsect <= i_countIsect;
          o_rsltSymdiff <= i_countSymdiff;
          o_rsltIdx <= win_cnt - 16'd1;
        end else o_overflow <= 1'b1;
      end else if (o_rsltValid && i_rsltReady) o_rsltValid <= 1'b0;
      if (state == IDLE) begin
        if (i_start && !i_stop) begin
          state <= RUN;
          o_busy <= 1'b1;
          o_windowLengthExp <= i_windowLengthExp > EW'(TIME_W) ? EW'(TIME_W) : i_windowLengthExp;
          nwin <= i_nWindows;
          win_cnt <= '0;
          first_done <= 1'b0;
          o_overflow <= 1'b0;
        end
      end else if (i_stop || done) begin
        state <= IDLE;
        o_busy <= 1'b0;
        o_t <= '0;
        o_zeroCounts <= 1'b1;
      end else begin
        o_t <= t_next;
        o_zeroCounts <= t_next == '0;
        if (o_zeroCounts) begin
          win_cnt <= win_cnt + 16'd1;
          first_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_corr_window_ctrl.sv
// tb_corr_window_ctrl: directed checks of window timing, capture, handshake, stop, gating and reset
module tb_corr_window_ctrl;
  localparam int DATA_W = 16, TIME_W = 8, EW = $clog2(TIME_W + 1);
  logic clk = 0, rst = 1, cg = 1, start = 0, stop = 0, ready = 1;
  logic [EW-1:0] exp_in = '0, exp_out;
  logic [15:0] nwin = '0, idx;
  logic [TIME_W-1:0] t;
  logic zc, valid, ovf, busy;
  logic [DATA_W-1:0] cx = '0, cy = '0, ci = '0, cs = '0, rx, ry, ri, rs;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  corr_window_ctrl #(.DATA_W(DATA_W), .TIME_W(TIME_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_start(start), .i_stop(stop),
    .i_windowLengthExp(exp_in), .i_nWindows(nwin), .o_t(t), .o_zeroCounts(zc),
    .o_windowLengthExp(exp_out), .i_countX(cx), .i_countY(cy), .i_countIsect(ci),
    .i_countSymdiff(cs), .o_rsltValid(valid), .i_rsltReady(ready), .o_rsltX(rx),
    .o_rsltY(ry), .o_rsltIsect(ri), .o_rsltSymdiff(rs), .o_rsltIdx(idx),
    .o_overflow(ovf), .o_busy(busy)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  initial begin
    step;
    step;
    rst = 0;
    chk("rst_t", 32'(t), 0);
    chk("rst_zc", 32'(zc), 1);
    chk("rst_exp", 32'(exp_out), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_x", 32'(rx), 0);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_busy", 32'(busy), 0);
    for (int i = 0; i < 10; i++) begin
      step;
      chk("idle_zc", 32'(zc), 1);
      chk("idle_t", 32'(t), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_valid", 32'(valid), 0);
    end
    // exp=2, three windows, X varies per cycle so each capture is distinguishable
    exp_in = 2; nwin = 3; cx = 5; cy = 6; ci = 7; cs = 8; ready = 1; start = 1;
    for (int c = 1; c <= 14; c++) begin
      step;
      start = 0;
      chk("run3_busy", 32'(busy), c <= 13 ? 1 : 0);
      chk("run3_t", 32'(t), c <= 13 ? (c - 1) % 4 : 0);
      chk("run3_zc", 32'(zc), c <= 13 ? ((c - 1) % 4 == 0 ? 1 : 0) : 1);
      chk("run3_valid", 32'(valid), (c == 6 || c == 10 || c == 14) ? 1 : 0);
      if (c == 6 || c == 10 || c == 14) begin
        chk("run3_idx", 32'(idx), (c - 6) / 4);
        chk("run3_x", 32'(rx), 100 + c - 1);
      end
      if (c == 6) begin
        chk("run3_y", 32'(ry), 6);
        chk("run3_isect", 32'(ri), 7);
        chk("run3_symdiff", 32'(rs), 8);
      end
      cx = DATA_W'(100 + c);
    end
    // clamped exponent: 2^8 window, one window
    exp_in = EW'(TIME_W + 3); nwin = 1; start = 1;
    for (int c = 1; c <= 258; c++) begin
      step;
      start = 0;
      if (c == 1) chk("clamp_exp", 32'(exp_out), TIME_W);
      if (c == 2) chk("clamp_t1", 32'(t), 1);
      if (c == 256) chk("clamp_t255", 32'(t), 255);
      if (c == 257) begin
        chk("clamp_wrap_t", 32'(t), 0);
        chk("clamp_wrap_zc", 32'(zc), 1);
      end
      if (c == 258) begin
        chk("clamp_end_busy", 32'(busy), 0);
        chk("clamp_end_valid", 32'(valid), 1);
        chk("clamp_end_idx", 32'(idx), 0);
      end
    end
    step;
    chk("drain_valid", 32'(valid), 0);
    // continuous with ready low: second capture is dropped
    ready = 0; exp_in = 1; nwin = 0; cx = 11; start = 1;
    step;
    start = 0;
    step;
    step;
    step;
    chk("ovf_first_valid", 32'(valid), 1);
    chk("ovf_first_x", 32'(rx), 11);
    chk("ovf_first_idx", 32'(idx), 0);
    chk("ovf_first_flag", 32'(ovf), 0);
    cx = 22;
    step;
    step;
    chk("ovf_flag", 32'(ovf), 1);
    chk("ovf_keep_x", 32'(rx), 11);
    chk("ovf_keep_idx", 32'(idx), 0);
    chk("ovf_keep_valid", 32'(valid), 1);
    stop = 1;
    step;
    stop = 0;
    chk("ovf_stop_busy", 32'(busy), 0);
    chk("ovf_stop_valid", 32'(valid), 1);
    chk("ovf_sticky", 32'(ovf), 1);
    start = 1; ready = 1;
    step;
    start = 0;
    chk("ovf_clear", 32'(ovf), 0);
    chk("ovf_restart_busy", 32'(busy), 1);
    chk("ovf_accept", 32'(valid), 0);
    stop = 1;
    step;
    stop = 0;
    chk("ovf_end_busy", 32'(busy), 0);
    // stop mid-window: no capture
    exp_in = 3; nwin = 0; start = 1;
    step;
    start = 0;
    step;
    step;
    chk("stopmid_t", 32'(t), 2);
    stop = 1;
    step;
    stop = 0;
    chk("stopmid_busy", 32'(busy), 0);
    chk("stopmid_t0", 32'(t), 0);
    chk("stopmid_zc", 32'(zc), 1);
    chk("stopmid_valid", 32'(valid), 0);
    step;
    chk("stopmid_valid2", 32'(valid), 0);
    // stop on a capture cycle: that capture still lands
    exp_in = 1; cx = 77; start = 1;
    step;
    start = 0;
    step;
    step;
    chk("stopcap_zc", 32'(zc), 1);
    stop = 1; cx = 78;
    step;
    stop = 0;
    chk("stopcap_busy", 32'(busy), 0);
    chk("stopcap_valid", 32'(valid), 1);
    chk("stopcap_x", 32'(rx), 78);
    chk("stopcap_idx", 32'(idx), 0);
    step;
    chk("stopcap_drain", 32'(valid), 0);
    // clock gate every other cycle: timeline of the ungated run, doubled
    exp_in = 1; nwin = 2; cx = 33; start = 1;
    for (int s = 1; s <= 13; s++) begin
      cg = s % 2 == 1;
      step;
      start = 0;
      begin
        int c;
        c = (s + 1) / 2;
        chk("cg_busy", 32'(busy), c <= 5 ? 1 : 0);
        chk("cg_t", 32'(t), c <= 5 ? (c - 1) % 2 : 0);
        chk("cg_valid", 32'(valid), (c == 4 || c == 6) ? 1 : 0);
        if (c == 4 || c == 6) begin
          chk("cg_idx", 32'(idx), c == 6 ? 1 : 0);
          chk("cg_x", 32'(rx), 33);
        end
      end
    end
    cg = 1;
    // async reset with a pending result
    ready = 0; exp_in = 3; nwin = 0; cx = 44; start = 1;
    for (int c = 1; c <= 12; c++) begin
      step;
      start = 0;
    end
    chk("arst_pre_valid", 32'(valid), 1);
    chk("arst_pre_t", 32'(t), 3);
    rst = 1;
    #2;
    chk("arst_t", 32'(t), 0);
    chk("arst_zc", 32'(zc), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(valid), 0);
    chk("arst_x", 32'(rx), 0);
    chk("arst_idx", 32'(idx), 0);
    chk("arst_exp", 32'(exp_out), 0);
    rst = 0;
    step;
    chk("arst_after_busy", 32'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
